fetch_sequencer: RTL and testbench

- Non-pipelined instruction fetch controller at the opposite end of the writeback next-PC path.
- Consumes the retired next PC and its update strobe from writeback, issues one instruction-memory read per instruction, and holds the fetched word for decode.
- Keeps the architectural PC register and a retired-instruction counter.
- Exactly one instruction is in flight between fetch and writeback at any time.

---
 rtl/fetch_sequencer.sv | 111 +++++++++++
 tb/tb_fetch_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Non-pipelined fetch controller: one instruction in flight from imem request to writeback retire.
// Latency: best case 4 cycles/instr; imem_req and imem_addr hold until granted, instr held until accepted.
module fetch_sequencer #(
  parameter logic [31:0] RESET_ADDR = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] next_pc,
  input  logic        pc_update,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        fetch_fault,
  output logic [31:0] instret
);

  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [2:0] {
    S_REQ,
    S_WAIT,
    S_DISPATCH,
    S_RETIRE,
    S_FAULT
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] instr_pc_q;
  logic        valid_q;
  logic        fault_q;
  logic        req_q;
  logic [31:0] instret_q;
  logic [31:0] instret_d;

  assign instret_d = instret_q + 32'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_ADDR;
      instr_q    <= NOP;
      instr_pc_q <= RESET_ADDR;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
      req_q      <= 1'b1;
      instret_q  <= 32'd0;
    end else begin
      case (state_q)
        S_REQ: begin
          if (imem_gnt) begin
            req_q   <= 1'b0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            instr_q    <= imem_rdata;
            instr_pc_q <= pc_q;
            valid_q    <= 1'b1;
            state_q    <= S_DISPATCH;
          end
        end
        S_DISPATCH: begin
          if (instr_ready) begin
            valid_q <= 1'b0;
            state_q <= S_RETIRE;
          end
        end
        S_RETIRE: begin
          if (pc_update) begin
            pc_q      <= next_pc;
            instret_q <= instret_d;
            // A misaligned target parks the core; pc keeps the bad address for debug.
            if (next_pc[1:0] != 2'b00) begin
              fault_q <= 1'b1;
              state_q <= S_FAULT;
            end else begin
              req_q   <= 1'b1;
              state_q <= S_REQ;
            end
          end
        end
        S_FAULT: begin
          state_q <= S_FAULT;
        end
        default: begin
          req_q   <= 1'b1;
          state_q <= S_REQ;
        end
      endcase
    end
  end

  // Gated with rst so no request leaks out while reset is still held.
  assign imem_req    = req_q & ~rst;
  assign imem_addr   = pc_q;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign fetch_fault = fault_q;
  assign instret     = instret_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized transaction-level bench for fetch_sequencer with an in-bench PC/instret model.
module tb_fetch_sequencer;

  localparam logic [31:0] RST_ADDR = 32'h00000100;
  localparam logic [31:0] NOP      = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] next_pc;
  logic        pc_update;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        fetch_fault;
  logic [31:0] instret;

  always #5 clk = ~clk;

  fetch_sequencer #(.RESET_ADDR(RST_ADDR)) dut (
    .clk         (clk),
    .rst         (rst),
    .next_pc     (next_pc),
    .pc_update   (pc_update),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .fetch_fault (fetch_fault),
    .instret     (instret)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  logic [31:0] m_pc;
  logic [31:0] m_instret;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h00000013;
  endfunction

  // Stray strobes in states where the DUT must ignore them.
  task automatic noise(input bit upd, input bit rv);
    if (upd) begin
      pc_update = ($urandom_range(0, 3) == 0);
      next_pc   = $urandom;
    end
    if (rv) begin
      imem_rvalid = ($urandom_range(0, 3) == 0);
      imem_rdata  = $urandom;
    end
  endtask

  task automatic run_instr(input int gd, input int rd, input int dd, input int ud,
                           input logic [31:0] word, input logic [31:0] npc,
                           input bit preload, output int cycles);
    int c0;
    c0 = cyc;
    check("req_start", imem_req, 1);
    check("addr_start", imem_addr, m_pc);
    repeat (gd) begin
      imem_gnt = 1'b0;
      noise(1, 1);
      step();
      check("req_hold", imem_req, 1);
      check("addr_hold", imem_addr, m_pc);
    end
    imem_gnt = 1'b1;
    noise(1, 1);
    step();
    imem_gnt = 1'b0;
    check("req_wait", imem_req, 0);
    repeat (rd) begin
      noise(1, 0);
      imem_rvalid = 1'b0;
      step();
      check("vld_wait", instr_valid, 0);
      check("instret_wait", instret, m_instret);
    end
    noise(1, 0);
    imem_rvalid = 1'b1;
    imem_rdata  = word;
    step();
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    check("vld_disp", instr_valid, 1);
    check("instr_disp", instr, word);
    check("ipc_disp", instr_pc, m_pc);
    if (preload) begin
      force dut.instret_q = 32'hFFFFFFFF;
      #1;
      release dut.instret_q;
      m_instret = 32'hFFFFFFFF;
    end
    repeat (dd) begin
      instr_ready = 1'b0;
      noise(1, 1);
      step();
      check("vld_bp", instr_valid, 1);
      check("instr_bp", instr, word);
      check("ipc_bp", instr_pc, m_pc);
      check("addr_bp", imem_addr, m_pc);
    end
    instr_ready = 1'b1;
    noise(1, 1);
    step();
    instr_ready = 1'b0;
    check("vld_drop", instr_valid, 0);
    repeat (ud) begin
      pc_update = 1'b0;
      next_pc   = $urandom;
      noise(0, 1);
      step();
      check("req_retire", imem_req, 0);
      check("instret_retire", instret, m_instret);
    end
    pc_update = 1'b1;
    next_pc   = npc;
    step();
    pc_update = 1'b0;
    m_instret = m_instret + 32'd1;
    m_pc      = npc;
    check("instret_inc", instret, m_instret);
    check("addr_next", imem_addr, m_pc);
    if (npc[1:0] != 2'b00) begin
      check("fault_set", fetch_fault, 1);
      check("req_fault", imem_req, 0);
    end else begin
      check("fault_clr", fetch_fault, 0);
      check("req_next", imem_req, 1);
    end
    cycles = cyc - c0;
  endtask

  task automatic reset_checks();
    check("rst_req", imem_req, 0);
    check("rst_vld", instr_valid, 0);
    check("rst_fault", fetch_fault, 0);
    check("rst_instret", instret, 0);
    check("rst_instr", instr, NOP);
    check("rst_ipc", instr_pc, RST_ADDR);
    check("rst_addr", imem_addr, RST_ADDR);
  endtask

  initial begin
    int c;
    logic [31:0] a;
    rst = 1'b1; next_pc = '0; pc_update = 1'b0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
    step();
    step();
    reset_checks();
    rst = 1'b0;
    #1;
    check("req_after_rst", imem_req, 1);
    m_pc = RST_ADDR;
    m_instret = '0;

    // Best case, then the redirect to 0x200.
    run_instr(0, 0, 0, 0, 32'h00500093, 32'h00000200, 1'b0, c);
    check("best_case_cycles", c, 4);
    // Grant withheld 3 cycles, decode backpressure 5 cycles.
    run_instr(3, 1, 5, 2, mem_word(m_pc), 32'h00000300, 1'b0, c);
    check("slow_cycles", c, 4 + 3 + 1 + 5 + 2);

    for (int i = 0; i < 30; i++) begin
      a = $urandom & 32'hFFFFFFFC;
      run_instr($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), mem_word(m_pc), a, (i == 10), c);
    end

    // Reset while a read is outstanding; the late response must be dropped.
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    check("req_wait2", imem_req, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEADBEEF;
    #1;
    check("rst_wait_req", imem_req, 1);
    check("rst_wait_addr", imem_addr, RST_ADDR);
    check("rst_wait_instret", instret, 0);
    step();
    imem_rvalid = 1'b0;
    check("late_rv_vld", instr_valid, 0);
    check("late_rv_instr", instr, NOP);
    check("late_rv_req", imem_req, 1);
    m_pc = RST_ADDR;
    m_instret = '0;
    run_instr(1, 0, 1, 0, mem_word(m_pc), 32'h00000400, 1'b0, c);

    // Misaligned target: sticky fault until reset.
    run_instr(0, 2, 0, 1, mem_word(m_pc), 32'h00000202, 1'b0, c);
    repeat (6) begin
      imem_gnt = ($urandom_range(0, 1) == 1);
      noise(1, 1);
      instr_ready = ($urandom_range(0, 1) == 1);
      step();
      check("fault_req", imem_req, 0);
      check("fault_vld", instr_valid, 0);
      check("fault_sticky", fetch_fault, 1);
      check("fault_pc", imem_addr, 32'h00000202);
      check("fault_instret", instret, m_instret);
    end
    imem_gnt = 1'b0; pc_update = 1'b0; imem_rvalid = 1'b0; instr_ready = 1'b0;
    rst = 1'b1;
    step();
    reset_checks();
    rst = 1'b0;
    #1;
    check("fault_rst_req", imem_req, 1);
    m_pc = RST_ADDR;
    m_instret = '0;
    run_instr(0, 0, 0, 0, mem_word(m_pc), 32'h00000104, 1'b0, c);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
